// File: rtl/hypot_iter_if.sv
// Handshake bundle for hypot_iter.
//   Start      : request, sampled only while Ready=1
//   X, Y       : W-bit unsigned operands, captured on an accepted Start
//   Ready      : unit is idle and will accept Start
//   Busy       : operation in progress (sum or root phase)
//   Done       : one-cycle pulse; Z/Exact update in the same cycle
//   Z          : W+1-bit magnitude, held until the next Done
//   Exact      : X*X+Y*Y is a perfect square, held with Z
interface hypot_iter_if #(
   parameter int unsigned W = 8
);
   logic         Start;
   logic [W-1:0] X;
   logic [W-1:0] Y;
   logic         Ready;
   logic         Busy;
   logic         Done;
   logic [W:0]   Z;
   logic         Exact;

   modport master (output Start, X, Y, input Ready, Busy, Done, Z, Exact);
   modport slave  (input Start, X, Y, output Ready, Busy, Done, Z, Exact);
endinterface

// File: rtl/hypot_iter.sv
// Sequential integer hypotenuse: Z = sqrt(X*X + Y*Y) for unsigned W-bit X, Y.
// Restoring digit-by-digit square root, one result bit per cycle.
//   Clock : rising-edge clock
//   Reset : synchronous, active-high; aborts any operation, clears Z/Exact
//   bus   : hypot_iter_if slave (Start/X/Y in, Ready/Busy/Done/Z/Exact out)
// Parameters:
//   W     : operand width (Z is W+1 bits)
//   ROUND : 0 = floor(sqrt), 1 = round to nearest
// Start accepted at edge k -> Done high in the cycle after edge k+W+2;
// one operation every W+4 cycles.
module hypot_iter #(
   parameter int unsigned W     = 8,
   parameter int unsigned ROUND = 0
) (
   input  logic         Clock,
   input  logic         Reset,
   hypot_iter_if.slave  bus
);

   localparam int unsigned SW = 2 * W + 2;   // sum register width, top bit always zero
   localparam int unsigned RW = W + 4;       // partial remainder / trial width
   localparam int unsigned ZW = W + 1;       // root width
   localparam int unsigned IW = $clog2(W + 1);

   typedef enum logic [1:0] {
      IDLE,
      SUM,
      ROOT,
      DONE
   } state_t;

   state_t          state;
   logic [W-1:0]    xr;
   logic [W-1:0]    yr;
   logic [SW-1:0]   s;
   logic [ZW-1:0]   root;
   logic [RW-1:0]   rem;
   logic [IW-1:0]   iter;

   logic            ready_r;
   logic            busy_r;
   logic            done_r;
   logic [ZW-1:0]   z_r;
   logic            exact_r;

   logic [SW-1:0]   sum_c;
   logic [1:0]      pair;
   logic [RW-1:0]   rem_sh;
   logic [RW-1:0]   trial;
   logic [RW-1:0]   rem_n;
   logic [ZW-1:0]   root_n;
   logic [ZW-1:0]   z_c;

   always_comb begin
      sum_c  = SW'(xr) * SW'(xr) + SW'(yr) * SW'(yr);
      // next two radicand bits, S[2*iter+1 : 2*iter]
      pair   = 2'(s >> {iter, 1'b0});
      rem_sh = (rem << 2) | RW'(pair);
      trial  = (RW'(root) << 2) | RW'(1);
      if (rem_sh >= trial) begin
         rem_n  = rem_sh - trial;
         root_n = (root << 1) | ZW'(1);
      end else begin
         rem_n  = rem_sh;
         root_n = root << 1;
      end
      // remainder above root means the true root is past root+0.5
      z_c = root_n;
      if (ROUND != 0 && rem_n > RW'(root_n)) begin
         z_c = root_n + ZW'(1);
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state   <= IDLE;
         xr      <= '0;
         yr      <= '0;
         s       <= '0;
         root    <= '0;
         rem     <= '0;
         iter    <= '0;
         ready_r <= 1'b1;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         z_r     <= '0;
         exact_r <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.Start) begin
                  xr      <= bus.X;
                  yr      <= bus.Y;
                  ready_r <= 1'b0;
                  busy_r  <= 1'b1;
                  state   <= SUM;
               end
            end
            SUM: begin
               s     <= sum_c;
               root  <= '0;
               rem   <= '0;
               iter  <= IW'(W);
               state <= ROOT;
            end
            ROOT: begin
               rem  <= rem_n;
               root <= root_n;
               if (iter == '0) begin
                  z_r     <= z_c;
                  exact_r <= (rem_n == '0);
                  done_r  <= 1'b1;
                  busy_r  <= 1'b0;
                  state   <= DONE;
               end else begin
                  iter <= iter - IW'(1);
               end
            end
            DONE: begin
               done_r  <= 1'b0;
               ready_r <= 1'b1;
               state   <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.Ready = ready_r;
   assign bus.Busy  = busy_r;
   assign bus.Done  = done_r;
   assign bus.Z     = z_r;
   assign bus.Exact = exact_r;

endmodule

// File: tb/tb_hypot_iter.sv
// Bench for hypot_iter: four instances (W=8/16, ROUND=0/1), directed cases
// on the W=8 pair, then a randomized back-to-back sweep on both pairs
// against an integer square-root model.
module tb_hypot_iter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start8 = 1'b0;
   logic        start16 = 1'b0;
   logic [7:0]  x8 = '0;
   logic [7:0]  y8 = '0;
   logic [15:0] x16 = '0;
   logic [15:0] y16 = '0;

   int n_checks = 0;
   int n_fail   = 0;
   int dones8   = 0;

   always #5 clk = ~clk;

   hypot_iter_if #(.W(8))  i8f ();
   hypot_iter_if #(.W(8))  i8r ();
   hypot_iter_if #(.W(16)) i16f ();
   hypot_iter_if #(.W(16)) i16r ();

   assign i8f.Start = start8;   assign i8f.X = x8;   assign i8f.Y = y8;
   assign i8r.Start = start8;   assign i8r.X = x8;   assign i8r.Y = y8;
   assign i16f.Start = start16; assign i16f.X = x16; assign i16f.Y = y16;
   assign i16r.Start = start16; assign i16r.X = x16; assign i16r.Y = y16;

   hypot_iter #(.W(8),  .ROUND(0)) u8f  (.Clock(clk), .Reset(rst), .bus(i8f));
   hypot_iter #(.W(8),  .ROUND(1)) u8r  (.Clock(clk), .Reset(rst), .bus(i8r));
   hypot_iter #(.W(16), .ROUND(0)) u16f (.Clock(clk), .Reset(rst), .bus(i16f));
   hypot_iter #(.W(16), .ROUND(1)) u16r (.Clock(clk), .Reset(rst), .bus(i16r));

   task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // floor(sqrt(s)) by binary search
   function automatic longint unsigned isqrt(input longint unsigned s);
      longint unsigned lo = 0;
      longint unsigned hi = 64'd262144;
      longint unsigned mid;
      while (lo < hi) begin
         mid = (lo + hi + 1) / 2;
         if (mid * mid <= s) lo = mid;
         else hi = mid - 1;
      end
      return lo;
   endfunction

   // nearest integer to sqrt(s): r+1 iff s > (r+0.5)^2, i.e. s > r*r + r
   function automatic longint unsigned rsqrt(input longint unsigned s);
      longint unsigned r = isqrt(s);
      return (s > r * r + r) ? r + 1 : r;
   endfunction

   task automatic inv(input string tag, input logic r, input logic b, input logic d);
      check({tag, "_rdy_busy_excl"}, r & b, 0);
      check({tag, "_both_low_is_done"}, (!r && !b), d);
   endtask

   task automatic rstate(input string tag, input logic r, input logic b, input logic d,
                         input longint unsigned z, input logic e);
      check({tag, "_ready"}, r, 1);
      check({tag, "_busy"}, b, 0);
      check({tag, "_done"}, d, 0);
      check({tag, "_z"}, z, 0);
      check({tag, "_exact"}, e, 0);
   endtask

   always @(negedge clk) begin
      inv("i8f", i8f.Ready, i8f.Busy, i8f.Done);
      inv("i8r", i8r.Ready, i8r.Busy, i8r.Done);
      inv("i16f", i16f.Ready, i16f.Busy, i16f.Done);
      inv("i16r", i16r.Ready, i16r.Busy, i16r.Done);
      if (i8f.Done) dones8++;
   end

   // One W=8 operation: Start pulse, optional extra Start while busy,
   // latency, results of both rounding modes, one-cycle Done.
   task automatic op8(input logic [7:0] x, input logic [7:0] y, input int ezf, input int ezr,
                      input bit eex, input bit poke, input string tag);
      int n;
      int d0;
      @(negedge clk);
      d0 = dones8;
      check({tag, "_ready_before"}, i8f.Ready, 1);
      start8 = 1'b1; x8 = x; y8 = y;
      @(negedge clk);
      start8 = 1'b0; x8 = ~x; y8 = ~y;
      n = 0;
      while (!i8f.Done && n < 40) begin
         start8 = (poke && n == 3);
         @(negedge clk);
         n++;
      end
      start8 = 1'b0;
      check({tag, "_latency"}, n, 10);
      check({tag, "_z_floor"}, i8f.Z, ezf);
      check({tag, "_z_round"}, i8r.Z, ezr);
      check({tag, "_exact_floor"}, i8f.Exact, eex);
      check({tag, "_exact_round"}, i8r.Exact, eex);
      @(negedge clk);
      check({tag, "_done_one_cycle"}, i8f.Done, 0);
      check({tag, "_ready_after"}, i8f.Ready, 1);
      check({tag, "_z_held"}, i8f.Z, ezf);
      check({tag, "_done_count"}, dones8 - d0, 1);
   endtask

   task automatic drive(input int w, input logic st, input longint unsigned x, input longint unsigned y);
      if (w == 8) begin
         start8 = st; x8 = 8'(x); y8 = 8'(y);
      end else begin
         start16 = st; x16 = 16'(x); y16 = 16'(y);
      end
   endtask

   // Start held high; operands re-randomized every cycle so that only the
   // values present at acceptance may influence the result.
   task automatic sweep(input int w, input int nops);
      longint unsigned qx[$];
      longint unsigned qy[$];
      int              qc[$];
      longint unsigned maxv = (w == 8) ? 255 : 65535;
      longint unsigned x, y, s, ex, ey;
      int              c;
      int              cyc = 0;
      int              issued = 0;
      int              last_done = -1;
      bit              finished = 0;
      logic            rdy, dn, exf, exr;
      longint unsigned zf, zr;
      for (int g = 0; g < nops * (w + 4) + 200; g++) begin
         @(negedge clk);
         cyc++;
         rdy = (w == 8) ? i8f.Ready : i16f.Ready;
         dn  = (w == 8) ? i8f.Done  : i16f.Done;
         zf  = (w == 8) ? longint'(i8f.Z) : longint'(i16f.Z);
         zr  = (w == 8) ? longint'(i8r.Z) : longint'(i16r.Z);
         exf = (w == 8) ? i8f.Exact : i16f.Exact;
         exr = (w == 8) ? i8r.Exact : i16r.Exact;
         if (dn) begin
            check("sw_expected_op", qx.size() > 0, 1);
            if (qx.size() > 0) begin
               ex = qx.pop_front(); ey = qy.pop_front(); c = qc.pop_front();
               s = ex * ex + ey * ey;
               check("sw_z_floor", zf, isqrt(s));
               check("sw_z_round", zr, rsqrt(s));
               check("sw_exact_floor", exf, isqrt(s) * isqrt(s) == s);
               check("sw_exact_round", exr, isqrt(s) * isqrt(s) == s);
               check("sw_latency", cyc - c, w + 3);
               if (last_done >= 0) check("sw_period", cyc - last_done, w + 4);
               last_done = cyc;
            end
            if (issued == nops && qx.size() == 0) begin
               finished = 1;
               break;
            end
         end
         x = ($urandom_range(0, 7) == 0) ? maxv : longint'($urandom_range(0, 32'(maxv)));
         y = ($urandom_range(0, 7) == 0) ? 0    : longint'($urandom_range(0, 32'(maxv)));
         if (rdy) begin
            if (issued < nops) begin
               drive(w, 1'b1, x, y);
               qx.push_back(x); qy.push_back(y); qc.push_back(cyc);
               issued++;
            end else begin
               drive(w, 1'b0, x, y);
            end
         end else begin
            drive(w, (issued < nops) || (qx.size() > 0), x, y);
         end
      end
      drive(w, 1'b0, 0, 0);
      check("sw_complete", finished, 1);
   endtask

   initial begin
      int d0;
      repeat (3) @(negedge clk);
      rstate("rst_i8f", i8f.Ready, i8f.Busy, i8f.Done, i8f.Z, i8f.Exact);
      rstate("rst_i8r", i8r.Ready, i8r.Busy, i8r.Done, i8r.Z, i8r.Exact);
      rstate("rst_i16f", i16f.Ready, i16f.Busy, i16f.Done, i16f.Z, i16f.Exact);
      rstate("rst_i16r", i16r.Ready, i16r.Busy, i16r.Done, i16r.Z, i16r.Exact);
      rst = 1'b0;

      op8(8'd3,   8'd4,   5,   5,   1'b1, 1'b0, "t1_3_4");
      op8(8'd255, 8'd255, 360, 361, 1'b0, 1'b0, "t2_255_255");
      op8(8'd2,   8'd3,   3,   4,   1'b0, 1'b0, "t3_2_3");
      op8(8'd1,   8'd2,   2,   2,   1'b0, 1'b0, "t3_1_2");
      op8(8'd1,   8'd1,   1,   1,   1'b0, 1'b0, "t3_1_1");

      d0 = dones8;
      op8(8'd0, 8'd0, 0, 0, 1'b1, 1'b1, "t4_zero");
      repeat (14) @(negedge clk);
      check("t4_single_done", dones8 - d0, 1);
      check("t4_still_idle", i8f.Ready, 1);

      // abort in the 4th ROOT cycle
      @(negedge clk);
      start8 = 1'b1; x8 = 8'd9; y8 = 8'd12;
      @(negedge clk);
      start8 = 1'b0;
      repeat (4) @(negedge clk);
      check("t5_busy_before_reset", i8f.Busy, 1);
      rst = 1'b1;
      @(negedge clk);
      rstate("t5_abort_i8f", i8f.Ready, i8f.Busy, i8f.Done, i8f.Z, i8f.Exact);
      rstate("t5_abort_i8r", i8r.Ready, i8r.Busy, i8r.Done, i8r.Z, i8r.Exact);
      rst = 1'b0;
      d0 = dones8;
      repeat (14) @(negedge clk);
      check("t5_no_done", dones8 - d0, 0);
      op8(8'd6, 8'd8, 10, 10, 1'b1, 1'b0, "t5_6_8");

      sweep(8, 60);
      repeat (3) @(negedge clk);
      sweep(16, 30);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
